// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory master.
// Holds the request sizes, FSM states and per-size byte-lane masks.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC0 = 2'b01,
    ACC1 = 2'b10,
    RESP = 2'b11
  } lsu_state_e;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  // The reserved encoding 2'b11 behaves as a word access.
  function automatic lsu_size_e norm_size(input logic [1:0] raw);
    case (raw)
      2'b00:   norm_size = SZ_BYTE;
      2'b01:   norm_size = SZ_HALF;
      default: norm_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(input lsu_size_e sz);
    case (sz)
      SZ_BYTE: size_mask = MASK_BYTE;
      SZ_HALF: size_mask = MASK_HALF;
      default: size_mask = MASK_WORD;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the memory master: store lane/enable placement over
// two words, and load extraction plus sign/zero extension from two words.
import lsu_pkg::*;

module lsu_align (
  input  lsu_size_e   size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [7:0]  be8,
  output logic [63:0] wd64,
  input  logic [31:0] rd_lo,
  input  logic [31:0] rd_hi,
  input  logic        is_unsigned,
  output logic [31:0] rdata
);

  logic [5:0]  shamt_s;
  logic [31:0] raw_s;

  // Shift store lanes up and load lanes down by the byte offset, then extend.
  always_comb begin
    shamt_s = {1'b0, off, 3'b000};
    be8     = {4'b0000, size_mask(size)} << off;
    wd64    = {32'h0000_0000, wdata} << shamt_s;
    raw_s   = 32'({rd_hi, rd_lo} >> shamt_s);
    case (size)
      SZ_BYTE: rdata = {{24{raw_s[7] & ~is_unsigned}}, raw_s[7:0]};
      SZ_HALF: rdata = {{16{raw_s[15] & ~is_unsigned}}, raw_s[15:0]};
      default: rdata = raw_s;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Single-request load/store initiator for a byte-enabled, 1-cycle-latency RAM.
// Word-crossing accesses are split into two RAM accesses (ACC0 then ACC1).
import lsu_pkg::*;

module lsu_mem_master #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int BYTE_WIDTH    = 8,
  parameter int BYTES         = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [1:0]                    req_size,
  input  logic                          req_unsigned,
  input  logic [ADDRESS_WIDTH-1:0]      req_addr,
  input  logic [BYTE_WIDTH*BYTES-1:0]   req_wdata,
  output logic                          resp_valid,
  output logic [BYTE_WIDTH*BYTES-1:0]   resp_rdata,
  output logic [ADDRESS_WIDTH-1:0]      mem_addr,
  output logic [BYTES-1:0]              mem_be,
  output logic [BYTE_WIDTH*BYTES-1:0]   mem_wdata,
  output logic                          mem_we,
  input  logic [BYTE_WIDTH*BYTES-1:0]   mem_rdata
);

  lsu_state_e                     state_r;
  lsu_state_e                     state_nx_s;
  logic                           accept_s;
  logic                           we_r;
  lsu_size_e                      size_r;
  logic                           uns_r;
  logic [ADDRESS_WIDTH-1:0]       addr_r;
  logic [31:0]                    wdata_r;
  logic [31:0]                    lo_buf_r;

  logic [7:0]                     be8_s;
  logic [63:0]                    wd64_s;
  logic [31:0]                    rd_lo_s;
  logic [31:0]                    rd_hi_s;
  logic [31:0]                    rdata_s;
  logic                           split_s;
  logic [ADDRESS_WIDTH-1:0]       addr0_s;
  logic [ADDRESS_WIDTH-1:0]       addr1_s;

  assign accept_s = (state_r == IDLE) && req_valid;
  assign split_s  = (be8_s[7:4] != 4'b0000);
  assign addr0_s  = {addr_r[ADDRESS_WIDTH-1:2], 2'b00};
  assign addr1_s  = addr0_s + {{(ADDRESS_WIDTH-3){1'b0}}, 3'b100};
  assign rd_lo_s  = split_s ? lo_buf_r : mem_rdata;
  assign rd_hi_s  = split_s ? mem_rdata : 32'h0000_0000;

  lsu_align u_align (
    .size        (size_r),
    .off         (addr_r[1:0]),
    .wdata       (wdata_r),
    .be8         (be8_s),
    .wd64        (wd64_s),
    .rd_lo       (rd_lo_s),
    .rd_hi       (rd_hi_s),
    .is_unsigned (uns_r),
    .rdata       (rdata_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Request capture on accept; first read word buffered while the second is fetched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_r     <= 1'b0;
      size_r   <= SZ_BYTE;
      uns_r    <= 1'b0;
      addr_r   <= '0;
      wdata_r  <= 32'h0000_0000;
      lo_buf_r <= 32'h0000_0000;
    end else begin
      if (accept_s) begin
        we_r    <= req_we;
        size_r  <= norm_size(req_size);
        uns_r   <= req_unsigned;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
      end
      if (state_r == ACC1) begin
        lo_buf_r <= mem_rdata;
      end
    end
  end

  // Next-state and RAM/response outputs, all decoded from the current state.
  always_comb begin
    state_nx_s = state_r;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    mem_addr   = '0;
    mem_be     = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    case (state_r)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nx_s = ACC0;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ACC0: begin
        mem_addr  = addr0_s;
        mem_be    = be8_s[3:0];
        mem_wdata = wd64_s[31:0];
        mem_we    = we_r;
        if (split_s) begin
          state_nx_s = ACC1;
        end else begin
          state_nx_s = RESP;
        end
      end
      ACC1: begin
        mem_addr   = addr1_s;
        mem_be     = be8_s[7:4];
        mem_wdata  = wd64_s[63:32];
        mem_we     = we_r;
        state_nx_s = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (we_r) begin
          resp_rdata = '0;
        end else begin
          resp_rdata = rdata_s;
        end
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

endmodule
